// File: rtl/laser_pool.sv
// Pool of independent laser slots: shoot-edge capture, frame-paced launch with
// cooldown, upward motion, hit/border retirement and per-pixel sprite output.
module laser_pool #(
    parameter int NUM_LASERS      = 3,
    parameter int CANNON_Y        = 470,
    parameter int UPPER_BORDER    = 100,
    parameter int SCALING         = 4,
    parameter int LASER_SPEED     = 6,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int X_OFFSET        = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_tick,
    input  logic                      shoot,
    input  logic [9:0]                cannon_x,
    input  logic [9:0]                hpos,
    input  logic [9:0]                vpos,
    input  logic [NUM_LASERS-1:0]     hit_alien,
    output logic [NUM_LASERS-1:0]     laser_active,
    output logic [10*NUM_LASERS-1:0]  laser_x,
    output logic [10*NUM_LASERS-1:0]  laser_y,
    output logic                      laser_gfx,
    output logic                      fire_pulse,
    output logic                      shot_dropped
);

    localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_FRAMES);
    localparam logic [9:0]      LAUNCH_Y = 10'(CANNON_Y);
    localparam logic [9:0]      MIN_Y    = 10'(UPPER_BORDER + LASER_SPEED);
    localparam logic [9:0]      STEP_Y   = 10'(LASER_SPEED);
    localparam logic [9:0]      X_OFS    = 10'(X_OFFSET);
    localparam logic [10:0]     BOX_W    = 11'(SCALING);
    localparam logic [10:0]     BOX_H    = 11'(4 * SCALING);

    logic                      shoot_q;
    logic                      arm_q;
    logic                      pending_q, pending_d;
    logic [CD_W-1:0]           cd_q, cd_d;
    logic [NUM_LASERS-1:0]     active_q, active_d;
    logic [10*NUM_LASERS-1:0]  x_q, x_d;
    logic [10*NUM_LASERS-1:0]  y_q, y_d;
    logic                      fire_q, fire_d;
    logic                      drop_q, drop_d;

    logic                      shoot_edge;
    logic                      launch;
    logic [NUM_LASERS-1:0]     free_slots;
    logic [NUM_LASERS-1:0]     launch_sel;
    logic [9:0]                launch_x;

    // arm_q blocks a level held through reset release from looking like an edge
    assign shoot_edge = shoot & ~shoot_q & arm_q;
    assign free_slots = ~active_q;
    assign launch_sel = free_slots & (~free_slots + NUM_LASERS'(1));
    assign launch     = frame_tick & pending_q & (cd_q == '0) & (|free_slots);
    assign launch_x   = cannon_x + X_OFS;

    always_comb begin
        pending_d = pending_q;
        cd_d      = cd_q;
        active_d  = active_q;
        x_d       = x_q;
        y_d       = y_q;
        fire_d    = launch;
        drop_d    = frame_tick & pending_q & ~launch;

        // A tick consumes the outstanding request; an edge on the same clk queues a new one
        if (frame_tick) begin
            pending_d = 1'b0;
        end
        if (shoot_edge) begin
            pending_d = 1'b1;
        end

        if (launch) begin
            cd_d = CD_LOAD;
        end else if (frame_tick && (cd_q != '0)) begin
            cd_d = cd_q - CD_W'(1);
        end

        for (int i = 0; i < NUM_LASERS; i++) begin
            if (frame_tick && active_q[i]) begin
                if (y_q[10*i +: 10] < MIN_Y) begin
                    active_d[i] = 1'b0;
                end else begin
                    y_d[10*i +: 10] = y_q[10*i +: 10] - STEP_Y;
                end
            end
            if (hit_alien[i] && active_q[i]) begin
                active_d[i] = 1'b0;
            end
            if (launch && launch_sel[i]) begin
                active_d[i]     = 1'b1;
                x_d[10*i +: 10] = launch_x;
                y_d[10*i +: 10] = LAUNCH_Y;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shoot_q   <= 1'b0;
            arm_q     <= 1'b0;
            pending_q <= 1'b0;
            cd_q      <= '0;
            active_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fire_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            shoot_q   <= shoot;
            arm_q     <= arm_q | ~shoot;
            pending_q <= pending_d;
            cd_q      <= cd_d;
            active_q  <= active_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fire_q    <= fire_d;
            drop_q    <= drop_d;
        end
    end

    // Boxes compared at 11 bits so a box touching row/column 1023 does not wrap
    always_comb begin
        laser_gfx = 1'b0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            if (active_q[i]
                && ({1'b0, hpos} >= {1'b0, x_q[10*i +: 10]})
                && ({1'b0, hpos} <  ({1'b0, x_q[10*i +: 10]} + BOX_W))
                && ({1'b0, vpos} >= {1'b0, y_q[10*i +: 10]})
                && ({1'b0, vpos} <  ({1'b0, y_q[10*i +: 10]} + BOX_H))) begin
                laser_gfx = 1'b1;
            end
        end
    end

    assign laser_active = active_q;
    assign laser_x      = x_q;
    assign laser_y      = y_q;
    assign fire_pulse   = fire_q;
    assign shot_dropped = drop_q;

endmodule

// File: tb/tb_laser_pool.sv
// Directed bench for laser_pool: expected launch/drop events are queued by the
// stimulus and consumed by a monitor whenever the DUT pulses fire_pulse or shot_dropped.
module tb_laser_pool;

    logic        clk;
    logic        reset_n;
    logic        frame_tick;
    logic        shoot;
    logic [9:0]  cannon_x;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic [2:0]  hit_alien;
    logic [2:0]  laser_active;
    logic [29:0] laser_x;
    logic [29:0] laser_y;
    logic        laser_gfx;
    logic        fire_pulse;
    logic        shot_dropped;

    // Single-slot instances whose launch rows land exactly on 106 and 105
    logic        b_active, b_gfx, b_fire, b_drop;
    logic [9:0]  b_x, b_y;
    logic        c_active, c_gfx, c_fire, c_drop;
    logic [9:0]  c_x, c_y;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         fire;
        int         slot;
        logic [2:0] act;
        logic [9:0] x;
        logic [9:0] y;
    } ev_t;
    ev_t exp_q[$];

    laser_pool dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .shoot(shoot),
        .cannon_x(cannon_x), .hpos(hpos), .vpos(vpos), .hit_alien(hit_alien),
        .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
        .laser_gfx(laser_gfx), .fire_pulse(fire_pulse), .shot_dropped(shot_dropped)
    );

    laser_pool #(.NUM_LASERS(1), .CANNON_Y(472)) dut_b (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .shoot(shoot),
        .cannon_x(cannon_x), .hpos(hpos), .vpos(vpos), .hit_alien(1'b0),
        .laser_active(b_active), .laser_x(b_x), .laser_y(b_y),
        .laser_gfx(b_gfx), .fire_pulse(b_fire), .shot_dropped(b_drop)
    );

    laser_pool #(.NUM_LASERS(1), .CANNON_Y(471)) dut_c (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .shoot(shoot),
        .cannon_x(cannon_x), .hpos(hpos), .vpos(vpos), .hit_alien(1'b0),
        .laser_active(c_active), .laser_x(c_x), .laser_y(c_y),
        .laser_gfx(c_gfx), .fire_pulse(c_fire), .shot_dropped(c_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press();
        shoot = 1'b1;
        cyc();
        shoot = 1'b0;
        cyc();
    endtask

    task automatic exp_fire(input int slot, input logic [2:0] act, input logic [9:0] x, input logic [9:0] y);
        ev_t e;
        e.fire = 1'b1; e.slot = slot; e.act = act; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic exp_drop(input logic [2:0] act);
        ev_t e;
        e.fire = 1'b0; e.slot = 0; e.act = act; e.x = '0; e.y = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: every launch/drop pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n && (fire_pulse || shot_dropped)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: fire=%0b drop=%0b, expected no event at %0t", fire_pulse, shot_dropped, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_fire", {31'd0, fire_pulse}, {31'd0, e.fire});
                chk("ev_drop", {31'd0, shot_dropped}, {31'd0, ~e.fire});
                chk("ev_active", {29'd0, laser_active}, {29'd0, e.act});
                if (e.fire) begin
                    chk("ev_x", {22'd0, laser_x[10*e.slot +: 10]}, {22'd0, e.x});
                    chk("ev_y", {22'd0, laser_y[10*e.slot +: 10]}, {22'd0, e.y});
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        shoot      = 1'b0;
        cannon_x   = 10'd0;
        hpos       = 10'd0;
        vpos       = 10'd0;
        hit_alien  = 3'b000;
        #2;
        chk("rst_active", {29'd0, laser_active}, 0);
        chk("rst_x", {2'd0, laser_x}, 0);
        chk("rst_y", {2'd0, laser_y}, 0);
        chk("rst_fire", {31'd0, fire_pulse}, 0);
        chk("rst_drop", {31'd0, shot_dropped}, 0);
        chk("rst_gfx", {31'd0, laser_gfx}, 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // First launch and motion
        cannon_x = 10'd200;
        press();
        exp_fire(0, 3'b001, 10'd206, 10'd470);
        tick();
        chk("l0_active", {29'd0, laser_active}, 32'b001);
        chk("l0_fire_now", {31'd0, fire_pulse}, 1);
        cyc();
        chk("l0_fire_gone", {31'd0, fire_pulse}, 0);
        ticks(3);
        chk("l0_y_after3", {22'd0, laser_y[9:0]}, 452);
        chk("l0_x_held", {22'd0, laser_x[9:0]}, 206);

        // Sprite box: x 206..209, y 452..467
        hpos = 10'd206; vpos = 10'd452; #1;
        chk("gfx_corner", {31'd0, laser_gfx}, 1);
        hpos = 10'd209; vpos = 10'd467; #1;
        chk("gfx_far_corner", {31'd0, laser_gfx}, 1);
        hpos = 10'd210; vpos = 10'd452; #1;
        chk("gfx_right_out", {31'd0, laser_gfx}, 0);
        hpos = 10'd206; vpos = 10'd468; #1;
        chk("gfx_bottom_out", {31'd0, laser_gfx}, 0);
        hpos = 10'd205; vpos = 10'd460; #1;
        chk("gfx_left_out", {31'd0, laser_gfx}, 0);
        hpos = 10'd0; vpos = 10'd0;

        // Request during cooldown (5 frames left) is dropped
        press();
        exp_drop(3'b001);
        tick();
        chk("cd_drop_pulse", {31'd0, shot_dropped}, 1);
        cyc();
        chk("cd_drop_gone", {31'd0, shot_dropped}, 0);

        // Cooldown now 4: after 4 ticks a launch is allowed; x wraps mod 1024
        ticks(4);
        cannon_x = 10'd1020;
        press();
        exp_fire(1, 3'b011, 10'd2, 10'd470);
        tick();
        chk("l1_active", {29'd0, laser_active}, 32'b011);

        ticks(8);
        cannon_x = 10'd50;
        press();
        exp_fire(2, 3'b111, 10'd56, 10'd470);
        tick();
        chk("l2_active", {29'd0, laser_active}, 32'b111);

        // Fourth request right away: no slot and cooldown active
        press();
        exp_drop(3'b111);
        tick();
        chk("full_no_launch", {29'd0, laser_active}, 32'b111);
        chk("y0_19", {22'd0, laser_y[9:0]}, 356);
        chk("y1_10", {22'd0, laser_y[19:10]}, 410);
        chk("y2_1", {22'd0, laser_y[29:20]}, 464);

        // Cooldown 7 -> 0, then a hit retires slot 1 between ticks
        ticks(7);
        hit_alien = 3'b010;
        cyc();
        hit_alien = 3'b000;
        chk("hit_active", {29'd0, laser_active}, 32'b101);
        chk("hit_y0", {22'd0, laser_y[9:0]}, 314);
        chk("hit_y1_held", {22'd0, laser_y[19:10]}, 368);
        chk("hit_y2", {22'd0, laser_y[29:20]}, 422);
        hit_alien = 3'b010;
        cyc();
        hit_alien = 3'b000;
        chk("hit_inactive_ignored", {29'd0, laser_active}, 32'b101);

        // Edge on the same clk as a tick does not launch on that tick
        shoot = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("same_clk_no_fire", {31'd0, fire_pulse}, 0);
        chk("same_clk_active", {29'd0, laser_active}, 32'b101);

        // Reset mid-flight with shoot held high
        hpos = 10'd56; vpos = 10'd430;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_active", {29'd0, laser_active}, 0);
        chk("mid_rst_x", {2'd0, laser_x}, 0);
        chk("mid_rst_y", {2'd0, laser_y}, 0);
        chk("mid_rst_fire", {31'd0, fire_pulse}, 0);
        chk("mid_rst_drop", {31'd0, shot_dropped}, 0);
        chk("mid_rst_gfx", {31'd0, laser_gfx}, 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        ticks(2);
        cyc();
        ticks(1);
        chk("held_shoot_no_launch", {29'd0, laser_active}, 0);
        chk("held_shoot_b", {31'd0, b_active}, 0);
        shoot = 1'b0;
        cyc();

        // Border behaviour: main reaches 110->104, dut_b 106, dut_c 105
        cannon_x = 10'd300;
        press();
        exp_fire(0, 3'b001, 10'd306, 10'd470);
        tick();
        chk("brd_b_launch_y", {22'd0, b_y}, 472);
        ticks(61);
        chk("brd_main_y104", {22'd0, laser_y[9:0]}, 104);
        chk("brd_main_act", {29'd0, laser_active}, 32'b001);
        chk("brd_b_y106", {22'd0, b_y}, 106);
        chk("brd_c_y105", {22'd0, c_y}, 105);
        tick();
        chk("brd_c_retired", {31'd0, c_active}, 0);
        chk("brd_c_y_kept", {22'd0, c_y}, 105);
        chk("brd_b_y100", {22'd0, b_y}, 100);
        chk("brd_b_active", {31'd0, b_active}, 1);
        chk("brd_main_retired", {29'd0, laser_active}, 0);
        chk("brd_main_y_kept", {22'd0, laser_y[9:0]}, 104);
        tick();
        chk("brd_b_retired", {31'd0, b_active}, 0);
        chk("brd_b_y_kept", {22'd0, b_y}, 100);

        cyc();
        cyc();
        chk("events_all_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_pool.md
LASER_POOL -- requirements
Module: laser_pool

Interface
REQ-001 SHALL have parameter NUM_LASERS, default 3: number of independent laser slots (1-8).
REQ-002 SHALL have parameter CANNON_Y, default 470: launch row.
REQ-003 SHALL have parameter UPPER_BORDER, default 100: top playfield row.
REQ-004 SHALL have parameter SCALING, default 4: sprite scale; laser box is 1*SCALING wide by 4*SCALING tall.
REQ-005 SHALL have parameter LASER_SPEED, default 6: rows moved per frame.
REQ-006 SHALL have parameter COOLDOWN_FRAMES, default 8: minimum frames between launches.
REQ-007 SHALL have parameter X_OFFSET, default 6: launch x offset from cannon_x.
REQ-008 SHALL have port clk, input, 1: pixel clock; all state is on its rising edge.
REQ-009 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port frame_tick, input, 1: one-clk pulse per frame; motion and cooldown advance only on it.
REQ-011 SHALL have port shoot, input, 1: fire button level.
REQ-012 SHALL have port cannon_x, input, 10: cannon left edge.
REQ-013 SHALL have ports hpos and vpos, input, 10 each: current beam position.
REQ-014 SHALL have port hit_alien, input, NUM_LASERS: per-slot hit flags.
REQ-015 SHALL have port laser_active, output, NUM_LASERS: slot i live.
REQ-016 SHALL have ports laser_x and laser_y, output, 10*NUM_LASERS each: slot i at bits [10i+9:10i].
REQ-017 SHALL have port laser_gfx, output, 1: beam inside any active laser box.
REQ-018 SHALL have port fire_pulse, output, 1: one-clk pulse when a slot launches.
REQ-019 SHALL have port shot_dropped, output, 1: one-clk pulse when a request is discarded.

Function
REQ-020 SHALL detect a rising edge of shoot: shoot=1 with the previous-clk sample 0; this sets the internal flag pending=1.
REQ-021 SHALL keep a held shoot from generating a second request until shoot returns to 0.
REQ-022 SHALL resolve pending only on a frame_tick clk, where pending is always cleared.
- If cooldown==0 and a slot was free at the start of that clk, the lowest-index free slot launches.
- Otherwise shot_dropped pulses.
REQ-023 SHALL, on launch of slot i:
- set laser_x[i] = cannon_x + X_OFFSET, modulo 1024;
- set laser_y[i] = CANNON_Y;
- set laser_active[i] = 1;
- load cooldown = COOLDOWN_FRAMES;
- pulse fire_pulse for that clk.
REQ-024 SHALL decrement a nonzero cooldown on every frame_tick that does not launch, saturating at 0.
REQ-025 SHALL, on each frame_tick, process every slot active at the start of that clk:
- if laser_y < UPPER_BORDER + LASER_SPEED: deactivate, laser_y unchanged (no underflow);
- else: laser_y -= LASER_SPEED.
REQ-026 SHALL give a newly launched slot no motion on its launch tick.
REQ-027 SHALL, when hit_alien[i]=1 on any clk while slot i is active, clear laser_active[i] at that edge, independent of frame_tick.
REQ-028 SHALL keep a slot freed by a hit or the border on a given clk unavailable for launch until the next frame_tick.
REQ-029 SHALL ignore hit_alien[i] while slot i is inactive.
REQ-030 SHALL hold laser_x and laser_y of inactive slots at their last values.
REQ-031 SHALL drive laser_gfx combinationally as the OR over active slots of (laser_x <= hpos < laser_x+SCALING) AND (laser_y <= vpos < laser_y+4*SCALING), with comparisons at 11 bits.
REQ-032 SHALL assert fire_pulse and shot_dropped for at most one clk each, never both together.

Reset
REQ-033 SHALL, while reset_n=0, immediately force to 0: laser_active, laser_x, laser_y, cooldown, pending, the shoot edge register, fire_pulse and shot_dropped; hence laser_gfx=0.
REQ-034 SHALL treat reset mid-flight as abandoning all lasers, and SHALL not count a shoot level held through reset release as an edge.

Verification
REQ-035 Default params; shoot edge then frame_tick, cannon_x=200 -> slot0 active, x=206, y=470; fire_pulse one clk; after 3 more ticks y=452.
REQ-036 Three edges, each followed by a tick, spaced 9 ticks apart -> slots 0,1,2 launch in order; a 4th edge on the next tick -> shot_dropped, no launch.
REQ-037 Edge at 2 ticks after a launch (cooldown still nonzero) -> shot_dropped; edge again once cooldown reaches 0 -> launch.
REQ-038 Slot at y=105, tick -> deactivated with y=105, no wrap; at y=106 -> y=100, stays active.
REQ-039 hit_alien[1] pulsed between ticks while slot1 active -> slot1 inactive the next clk, others unaffected; edge plus tick the same clk -> slot1 not reused that tick.
REQ-040 reset_n pulsed low with 2 active slots and shoot held high -> all outputs 0 immediately; no launch after release until shoot toggles.
